digit_serial_addsub: RTL and testbench

Parametrised, multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, least-significant digit first, rippling the carry between cycles through a carry register. Successor to the team's fixed 4-bit ripple adder. Trades latency for area on wide datapaths. Adds a start/busy/done handshake, a subtract mode and a signed-overflow flag. Sits between an operand-producing controller and a result consumer that samples on `done`.

---
 rtl/digit_serial_addsub_if.sv | 26 ++
 rtl/digit_serial_addsub.sv | 99 +++++++++
 tb/tb_digit_serial_addsub.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_addsub_if.sv
// Operand/result bundle between an operand-producing controller (master)
// and the digit-serial adder/subtractor (slave).
interface digit_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice per clock, LS digit first,
// carry rippled between cycles through c_q. Subtract runs as a + ~b + ~cin.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic clk,
    input logic rst_n,
    digit_serial_addsub_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]    LAST       = CW'(NDIG - 1);
    localparam logic [WIDTH-1:0] DIGIT_MASK = WIDTH'({DIGIT{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt_q;

    int               shift;
    logic [DIGIT-1:0] aDigit;
    logic [DIGIT-1:0] bDigit;
    logic [DIGIT:0]   digitSum;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;

    // Overflow uses the sign rule on the top digit, which equals carry-into-MSB
    // XOR carry-out; it is only consumed when the top digit is processed.
    always_comb begin
        shift    = int'(cnt_q) * DIGIT;
        aDigit   = DIGIT'(a_q >> shift);
        bDigit   = DIGIT'(b_q >> shift);
        digitSum = {1'b0, aDigit} + {1'b0, bDigit} + {{DIGIT{1'b0}}, c_q};
        sum_d    = (sum_q & ~(DIGIT_MASK << shift))
                 | (WIDTH'(digitSum[DIGIT-1:0]) << shift);
        ovf_d    = (aDigit[DIGIT-1] ~^ bDigit[DIGIT-1])
                 & (digitSum[DIGIT-1] ^ aDigit[DIGIT-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        c_q     <= bus.sub ^ bus.cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q <= sum_d;
                    c_q   <= digitSum[DIGIT];
                    if (cnt_q == LAST) begin
                        cout_q  <= digitSum[DIGIT];
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: directed 16/4 vectors plus random sweeps on
// 8/1, 16/16 and 32/8 instances, all checked every cycle against an arithmetic model.
module tb_digit_serial_addsub;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic        drvStart[NI];
    logic        drvSub[NI];
    logic        drvCin[NI];
    logic [63:0] drvA[NI];
    logic [63:0] drvB[NI];
    logic        obsBusy[NI];
    logic        obsDone[NI];
    logic        obsCout[NI];
    logic        obsOvf[NI];
    logic [63:0] obsSum[NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int widthOf(input int i);
        case (i)
            0: return 16;
            1: return 8;
            2: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int ndigOf(input int i);
        case (i)
            0: return 4;
            1: return 8;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    digit_serial_addsub_if #(.WIDTH(16)) if0 ();
    digit_serial_addsub_if #(.WIDTH(8))  if1 ();
    digit_serial_addsub_if #(.WIDTH(16)) if2 ();
    digit_serial_addsub_if #(.WIDTH(32)) if3 ();

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    digit_serial_addsub #(.WIDTH(8),  .DIGIT(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    digit_serial_addsub #(.WIDTH(32), .DIGIT(8))  dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    assign if0.start = drvStart[0];  assign if0.sub = drvSub[0];  assign if0.cin = drvCin[0];
    assign if0.a = drvA[0][15:0];    assign if0.b = drvB[0][15:0];
    assign obsBusy[0] = if0.busy;    assign obsDone[0] = if0.done;
    assign obsCout[0] = if0.cout;    assign obsOvf[0] = if0.ovf;
    assign obsSum[0] = {48'd0, if0.sum};

    assign if1.start = drvStart[1];  assign if1.sub = drvSub[1];  assign if1.cin = drvCin[1];
    assign if1.a = drvA[1][7:0];     assign if1.b = drvB[1][7:0];
    assign obsBusy[1] = if1.busy;    assign obsDone[1] = if1.done;
    assign obsCout[1] = if1.cout;    assign obsOvf[1] = if1.ovf;
    assign obsSum[1] = {56'd0, if1.sum};

    assign if2.start = drvStart[2];  assign if2.sub = drvSub[2];  assign if2.cin = drvCin[2];
    assign if2.a = drvA[2][15:0];    assign if2.b = drvB[2][15:0];
    assign obsBusy[2] = if2.busy;    assign obsDone[2] = if2.done;
    assign obsCout[2] = if2.cout;    assign obsOvf[2] = if2.ovf;
    assign obsSum[2] = {48'd0, if2.sum};

    assign if3.start = drvStart[3];  assign if3.sub = drvSub[3];  assign if3.cin = drvCin[3];
    assign if3.a = drvA[3][31:0];    assign if3.b = drvB[3][31:0];
    assign obsBusy[3] = if3.busy;    assign obsDone[3] = if3.done;
    assign obsCout[3] = if3.cout;    assign obsOvf[3] = if3.ovf;
    assign obsSum[3] = {32'd0, if3.sum};

    // Reference arithmetic: plain integer add/subtract, signed range test for ovf,
    // unsigned "no borrow" test for the subtract carry.
    function automatic void modelOp(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input bit sub, input bit cin,
                                    output logic [63:0] s, output bit co, output bit ov);
        longint mask, half, ua, ub, sa, sb, c, r;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        c    = cin ? 1 : 0;
        if (sub) begin
            r  = sa - sb - c;
            s  = 64'((ua - ub - c) & mask);
            co = (ua >= ub + c);
        end else begin
            r  = sa + sb + c;
            s  = 64'((ua + ub + c) & mask);
            co = ((ua + ub + c) > mask);
        end
        ov = (r >= half) || (r < -half);
    endfunction

    task automatic cmp(input string name, input int inst, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s inst%0d cyc%0d: got %h, expected %h", name, inst, cyc, got, want);
        end
    endtask

    bit          modelValid = 1'b0;
    bit          pend[NI];
    int          tAcc[NI];
    logic [63:0] expSum[NI];
    bit          expCout[NI];
    bit          expOvf[NI];
    logic [63:0] heldSum[NI];
    bit          heldCout[NI];
    bit          heldOvf[NI];

    // Per-cycle compare: busy in t+1..t+NDIG, done at t+NDIG+1, results held otherwise.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int nd;
            bit eb, ed, fr;
            nd = ndigOf(i);
            eb = pend[i] && (cyc >= tAcc[i] + 1) && (cyc <= tAcc[i] + nd);
            ed = pend[i] && (cyc == tAcc[i] + nd + 1);
            if (modelValid) begin
                if (ed) begin
                    heldSum[i]  = expSum[i];
                    heldCout[i] = expCout[i];
                    heldOvf[i]  = expOvf[i];
                end
                cmp("busy", i, 64'(obsBusy[i]), 64'(eb));
                cmp("done", i, 64'(obsDone[i]), 64'(ed));
                if (!eb) cmp("sum", i, obsSum[i], heldSum[i]);
                cmp("cout", i, 64'(obsCout[i]), 64'(heldCout[i]));
                cmp("ovf", i, 64'(obsOvf[i]), 64'(heldOvf[i]));
            end
            fr = !pend[i] || (cyc >= tAcc[i] + nd + 1);
            if (!rst_n) begin
                pend[i]     = 1'b0;
                heldSum[i]  = '0;
                heldCout[i] = 1'b0;
                heldOvf[i]  = 1'b0;
            end else if (modelValid && drvStart[i] && fr) begin
                pend[i] = 1'b1;
                tAcc[i] = cyc;
                modelOp(widthOf(i), drvA[i], drvB[i], drvSub[i], drvCin[i],
                        expSum[i], expCout[i], expOvf[i]);
            end else if (fr) begin
                pend[i] = 1'b0;
            end
        end
        if (!rst_n) modelValid = 1'b1;
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one start cycle, then scrambles the don't-care operand inputs.
    task automatic applyStimulus(input int i, input logic [63:0] a, input logic [63:0] b,
                                 input bit sub, input bit cin);
        drvA[i]     = a;
        drvB[i]     = b;
        drvSub[i]   = sub;
        drvCin[i]   = cin;
        drvStart[i] = 1'b1;
        waitCycles(1);
        drvStart[i] = 1'b0;
        drvA[i]     = {$urandom, $urandom};
        drvB[i]     = {$urandom, $urandom};
        drvSub[i]   = 1'($urandom);
        drvCin[i]   = 1'($urandom);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] s, input bit co,
                               input bit ov, input bit dn);
        cmp({name, ".done"}, 0, 64'(obsDone[0]), 64'(dn));
        cmp({name, ".sum"}, 0, obsSum[0], s);
        cmp({name, ".cout"}, 0, 64'(obsCout[0]), 64'(co));
        cmp({name, ".ovf"}, 0, 64'(obsOvf[0]), 64'(ov));
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            drvStart[i] = 1'b0;
            drvSub[i]   = 1'b0;
            drvCin[i]   = 1'b0;
            drvA[i]     = '0;
            drvB[i]     = '0;
        end
        rst_n       = 1'b0;
        drvStart[0] = 1'b1;
        drvA[0]     = 64'({$urandom});
        drvB[0]     = 64'({$urandom});
        #1;
        waitCycles(3);
        checkOutput("reset", 64'h0, 1'b0, 1'b0, 1'b0);
        cmp("reset.busy", 0, 64'(obsBusy[0]), 64'd0);
        rst_n       = 1'b1;
        drvStart[0] = 1'b0;
        waitCycles(1);

        applyStimulus(0, 64'h1234, 64'h4321, 1'b0, 1'b0);
        cmp("add1.busy_t1", 0, 64'(obsBusy[0]), 64'd1);
        waitCycles(3);
        cmp("add1.busy_t4", 0, 64'(obsBusy[0]), 64'd1);
        cmp("add1.done_t4", 0, 64'(obsDone[0]), 64'd0);
        waitCycles(1);
        checkOutput("add1", 64'h5555, 1'b0, 1'b0, 1'b1);

        applyStimulus(0, 64'hFFFF, 64'h0001, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("addwrap", 64'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, 64'h7FFF, 64'h0001, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("addovf", 64'h8000, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 64'h0005, 64'h0007, 1'b1, 1'b0);
        waitCycles(4);
        checkOutput("subneg", 64'hFFFE, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 64'h8000, 64'h0001, 1'b1, 1'b0);
        waitCycles(4);
        checkOutput("subovf", 64'h7FFF, 1'b1, 1'b1, 1'b1);
        applyStimulus(0, 64'h0010, 64'h0001, 1'b1, 1'b1);
        waitCycles(4);
        checkOutput("subborrow", 64'h000E, 1'b1, 1'b0, 1'b1);

        applyStimulus(0, 64'h1111, 64'h2222, 1'b0, 1'b0);
        waitCycles(1);
        drvA[0] = 64'hAAAA;  drvB[0] = 64'h5555;  drvSub[0] = 1'b1;  drvStart[0] = 1'b1;
        waitCycles(1);
        drvStart[0] = 1'b0;
        waitCycles(2);
        checkOutput("startinrun", 64'h3333, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 64'h0001, 64'h0001, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("backtoback", 64'h0002, 1'b0, 1'b0, 1'b1);

        waitCycles(1);
        applyStimulus(0, 64'h00FF, 64'h0101, 1'b0, 1'b0);
        waitCycles(1);
        rst_n = 1'b0;
        waitCycles(1);
        rst_n = 1'b1;
        checkOutput("midreset", 64'h0, 1'b0, 1'b0, 1'b0);
        cmp("midreset.busy", 0, 64'(obsBusy[0]), 64'd0);
        waitCycles(4);
        applyStimulus(0, 64'h0F0F, 64'h0101, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("afterreset", 64'h1010, 1'b0, 1'b0, 1'b1);

        for (int i = 1; i < NI; i++) begin
            logic [63:0] mask;
            mask = (64'd1 << widthOf(i)) - 64'd1;
            waitCycles(1);
            for (int k = 0; k < 1000; k++) begin
                logic [63:0] ra, rb;
                ra = {$urandom, $urandom} & mask;
                rb = {$urandom, $urandom} & mask;
                if (k % 50 == 0) begin
                    ra = mask;
                    rb = 64'd1;
                end else if (k % 50 == 1) begin
                    ra = mask >> 1;
                    rb = 64'd1;
                end
                applyStimulus(i, ra, rb, 1'($urandom), 1'($urandom));
                waitCycles(ndigOf(i));
                if (k % 4 == 3) waitCycles(1);
            end
        end

        waitCycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "[TB] timeout");
    end
endmodule
